temporizador_irrigacao: RTL and testbench
=========================================

Name: temporizador_irrigacao

Overview:
Irrigation countdown timer that consumes the four BCD preset digits (MM:SS) produced by the preset generator. It loads them on a start command and drives the valve while counting down to 00:00 at 1 Hz. The 1 Hz tick comes from an internal prescaler. Current digits go to the display path; the block signals completion to the top-level controller.

Parameters:
CLK_FREQ, 50000000, clock cycles per 1 s tick; must be >= 2; bench uses 4.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
iniciar  input  1  start request, sampled each clk edge
pausar  input  1  level; freeze countdown while high
parar  input  1  abort request, sampled each clk edge
dez_minutopreset  input  4  BCD tens of minutes preset
unid_minutopreset  input  4  BCD units of minutes preset
dez_segundopreset  input  4  BCD tens of seconds preset
unid_segundopreset  input  4  BCD units of seconds preset
dez_minuto  output  4  current BCD tens of minutes
unid_minuto  output  4  current BCD units of minutes
dez_segundo  output  4  current BCD tens of seconds
unid_segundo  output  4  current BCD units of seconds
valvula  output  1  valve drive, registered
ocupado  output  1  high in CONTANDO or PAUSADO
fim  output  1  one-cycle pulse on completion
erro_preset  output  1  one-cycle pulse on invalid preset

Behaviour:
- Reset (async, rst_n=0): state OCIOSO, all digits 0, prescaler 0, valvula=0, ocupado=0, fim=0, erro_preset=0.
- States: OCIOSO, CONTANDO, PAUSADO, FIM. All outputs are registered.
- Preset validity: each digit <= 9 and dez_segundopreset <= 5.
- OCIOSO + iniciar:
  - Invalid preset: erro_preset pulses next cycle; state and digits unchanged.
  - Valid, all-zero preset: load 00:00, go to FIM; valvula stays 0.
  - Valid, non-zero preset: on the next edge, digits = preset, state CONTANDO, valvula=1, prescaler=0.
- CONTANDO:
  - Prescaler increments each cycle and wraps at CLK_FREQ-1; the tick is the cycle where it equals CLK_FREQ-1.
  - First decrement occurs exactly CLK_FREQ cycles after entering CONTANDO.
- Decrement on tick (BCD borrow chain):
  - unid_segundo>0: decrement it.
  - Else unid_segundo=9 and borrow from dez_segundo.
  - dez_segundo=0 on borrow: set it to 5 and borrow from unid_minuto.
  - unid_minuto=0 on borrow: set it to 9 and decrement dez_minuto.
- 00:01 on tick: digits become 00:00, state FIM, valvula=0, all on the same edge.
- pausar high in CONTANDO: next edge goes to PAUSADO. Prescaler holds, valvula=0, digits hold.
- pausar low in PAUSADO: next edge returns to CONTANDO, valvula=1, prescaler resumes from its held value.
- Tick coincident with pausar rising: pausar wins; no decrement, prescaler holds.
- FIM: fim=1 for exactly one cycle, then OCIOSO. Digits hold 00:00 until the next load.
- parar in CONTANDO or PAUSADO: next edge goes to OCIOSO, valvula=0, digits hold last value, no fim pulse.
- Priority: parar > pausar > tick; parar also overrides iniciar in OCIOSO (no load).
- iniciar outside OCIOSO is ignored; preset changes are ignored after load.
- rst_n asserted mid-count: immediate return to reset values; valve closes asynchronously.

Decomposition:
- Shared package: state encoding (OCIOSO, CONTANDO, PAUSADO, FIM), BCD limits MAX_UNID=9 and MAX_DEZ_SEG=5, digit width 4.
- Sub-module divisor_tick: prescaler with enable, synchronous clear and tick output, parameterised by CLK_FREQ.

Test Plan (CLK_FREQ=4):
- Preset 00:03, iniciar pulse -> valvula=1 next cycle; digits 00:02, 00:01, 00:00 at +4, +8, +12 cycles; valvula=0 and state FIM at +12; fim high one cycle at +13; ocupado low from +13.
- Preset 01:00, run one tick -> digits 00:59; a further tick gives 00:58 (full borrow chain).
- Preset 00:05, pausar high for 10 cycles after the 2nd tick -> digits frozen at 00:03 and valvula=0 while paused; next decrement occurs 4 cycles after pause release, counting from the held prescaler value.
- Preset 00:07 (tens of seconds=0, valid) vs preset 00:70 (dez_segundopreset=7) -> the valid preset loads; the invalid one gives erro_preset one-cycle pulse, state stays OCIOSO, valvula stays 0.
- Preset 00:00 + iniciar -> fim pulse within 2 cycles, valvula never asserted.
- Mid-count parar with iniciar asserted on the same edge -> OCIOSO, valvula=0, digits hold, no reload. Repeat with rst_n pulsed low mid-count -> immediate 00:00, valvula=0.

Source files
------------

// File: rtl/temporizador_irrigacao_pkg.sv
// Shared types for the irrigation countdown timer: FSM encoding,
// BCD limits and the MM:SS digit bundle with its helpers.
package temporizador_irrigacao_pkg;

  localparam int DIG_W = 4;

  localparam logic [DIG_W-1:0] MAX_UNID    = 4'd9;
  localparam logic [DIG_W-1:0] MAX_DEZ_SEG = 4'd5;

  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] CONTANDO = 2'd1;
  localparam logic [1:0] PAUSADO  = 2'd2;
  localparam logic [1:0] FIM      = 2'd3;

  typedef struct packed {
    logic [DIG_W-1:0] dm;
    logic [DIG_W-1:0] um;
    logic [DIG_W-1:0] ds;
    logic [DIG_W-1:0] us;
  } tempo_t;

  function automatic logic preset_valido(
    input tempo_t t
  );
    return (t.dm <= MAX_UNID) &&
           (t.um <= MAX_UNID) &&
           (t.ds <= MAX_DEZ_SEG) &&
           (t.us <= MAX_UNID);
  endfunction

  function automatic logic eh_zero(
    input tempo_t t
  );
    return t == '0;
  endfunction

  // One-second BCD borrow chain, seconds first.
  function automatic tempo_t decrementa(
    input tempo_t t
  );
    tempo_t r;
    r = t;
    if (t.us != '0) begin
      r.us = t.us - 4'd1;
    end else begin
      r.us = MAX_UNID;
      if (t.ds != '0) begin
        r.ds = t.ds - 4'd1;
      end else begin
        r.ds = MAX_DEZ_SEG;
        if (t.um != '0) begin
          r.um = t.um - 4'd1;
        end else begin
          r.um = MAX_UNID;
          r.dm = t.dm - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/temporizador_irrigacao_divisor_tick.sv
// Prescaler producing a one-cycle tick every CLK_FREQ enabled cycles;
// holds its count while disabled so a paused countdown resumes in place.
module divisor_tick #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW =
    (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CW-1:0] MAXV =
    CW'(CLK_FREQ - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == MAXV) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign tick_o = en_i && !clr_i &&
                  (cnt_q == MAXV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/temporizador_irrigacao.sv
// Irrigation countdown timer: loads an MM:SS BCD preset, opens the
// valve and counts down to 00:00 at 1 Hz with pause and abort.
module temporizador_irrigacao
  import temporizador_irrigacao_pkg::*;
#(
  parameter int CLK_FREQ = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iniciar,
  input  logic             pausar,
  input  logic             parar,
  input  logic [DIG_W-1:0] dez_minutopreset,
  input  logic [DIG_W-1:0] unid_minutopreset,
  input  logic [DIG_W-1:0] dez_segundopreset,
  input  logic [DIG_W-1:0] unid_segundopreset,
  output logic [DIG_W-1:0] dez_minuto,
  output logic [DIG_W-1:0] unid_minuto,
  output logic [DIG_W-1:0] dez_segundo,
  output logic [DIG_W-1:0] unid_segundo,
  output logic             valvula,
  output logic             ocupado,
  output logic             fim,
  output logic             erro_preset
);

  logic [1:0] state_q, state_d;
  tempo_t     tempo_q, tempo_d;
  logic       valvula_q, valvula_d;
  logic       ocupado_q, ocupado_d;
  logic       fim_q, fim_d;
  logic       erro_q, erro_d;

  tempo_t preset;
  tempo_t tempo_dec;
  logic   carregar;
  logic   conta_en;
  logic   tick;

  assign preset = {dez_minutopreset,
                   unid_minutopreset,
                   dez_segundopreset,
                   unid_segundopreset};

  assign tempo_dec = decrementa(tempo_q);

  // Abort and pause both win over a coincident tick.
  assign conta_en = (state_q == CONTANDO) &&
                    !parar && !pausar;

  divisor_tick #(
    .CLK_FREQ (CLK_FREQ)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (conta_en),
    .clr_i  (carregar),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    tempo_d  = tempo_q;
    fim_d    = 1'b0;
    erro_d   = 1'b0;
    carregar = 1'b0;
    unique case (state_q)
      OCIOSO: begin
        if (!parar && iniciar) begin
          if (!preset_valido(preset)) begin
            erro_d = 1'b1;
          end else if (eh_zero(preset)) begin
            tempo_d = '0;
            state_d = FIM;
          end else begin
            tempo_d  = preset;
            state_d  = CONTANDO;
            carregar = 1'b1;
          end
        end
      end
      CONTANDO: begin
        if (parar) begin
          state_d = OCIOSO;
        end else if (pausar) begin
          state_d = PAUSADO;
        end else if (tick) begin
          tempo_d = tempo_dec;
          if (eh_zero(tempo_dec)) begin
            state_d = FIM;
          end
        end
      end
      PAUSADO: begin
        if (parar) begin
          state_d = OCIOSO;
        end else if (!pausar) begin
          state_d = CONTANDO;
        end
      end
      FIM: begin
        fim_d   = 1'b1;
        state_d = OCIOSO;
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase
  end

  assign valvula_d = (state_d == CONTANDO);
  assign ocupado_d = (state_d == CONTANDO) ||
                     (state_d == PAUSADO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OCIOSO;
      tempo_q   <= '0;
      valvula_q <= 1'b0;
      ocupado_q <= 1'b0;
      fim_q     <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tempo_q   <= tempo_d;
      valvula_q <= valvula_d;
      ocupado_q <= ocupado_d;
      fim_q     <= fim_d;
      erro_q    <= erro_d;
    end
  end

  assign dez_minuto   = tempo_q.dm;
  assign unid_minuto  = tempo_q.um;
  assign dez_segundo  = tempo_q.ds;
  assign unid_segundo = tempo_q.us;
  assign valvula      = valvula_q;
  assign ocupado      = ocupado_q;
  assign fim          = fim_q;
  assign erro_preset  = erro_q;

endmodule

// File: tb/tb_temporizador_irrigacao.sv
// Directed-vector bench for the irrigation timer at CLK_FREQ=4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_temporizador_irrigacao;

  logic       clk;
  logic       rst_n;
  logic       iniciar, pausar, parar;
  logic [3:0] p_dm, p_um, p_ds, p_us;
  logic [3:0] dm, um, ds, us;
  logic       valvula, ocupado, fim, erro;
  logic [15:0] dig;

  int n_vec;
  int n_err;

  assign dig = {dm, um, ds, us};

  temporizador_irrigacao #(
    .CLK_FREQ (4)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .iniciar            (iniciar),
    .pausar             (pausar),
    .parar              (parar),
    .dez_minutopreset   (p_dm),
    .unid_minutopreset  (p_um),
    .dez_segundopreset  (p_ds),
    .unid_segundopreset (p_us),
    .dez_minuto         (dm),
    .unid_minuto        (um),
    .dez_segundo        (ds),
    .unid_segundo       (us),
    .valvula            (valvula),
    .ocupado            (ocupado),
    .fim                (fim),
    .erro_preset        (erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_preset(input logic [15:0] p);
    {p_dm, p_um, p_ds, p_us} = p;
  endtask

  task automatic start(input logic [15:0] p);
    set_preset(p);
    iniciar = 1'b1;
    step(1);
    iniciar = 1'b0;
  endtask

  task automatic stop();
    parar = 1'b1;
    step(1);
    parar = 1'b0;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    iniciar = 1'b0;
    pausar  = 1'b0;
    parar   = 1'b0;
    set_preset(16'h0000);
    step(2);
    check("rst_dig", dig, 16'h0000);
    check("rst_valv", 16'(valvula), 16'd0);
    check("rst_ocup", 16'(ocupado), 16'd0);
    check("rst_fim", 16'(fim), 16'd0);
    check("rst_erro", 16'(erro), 16'd0);
    rst_n = 1'b1;
    step(1);

    // 00:03 full countdown
    start(16'h0003);
    check("t1_load", dig, 16'h0003);
    check("t1_valv", 16'(valvula), 16'd1);
    check("t1_ocup", 16'(ocupado), 16'd1);
    step(3);
    check("t1_p3", dig, 16'h0003);
    step(1);
    check("t1_p4", dig, 16'h0002);
    step(4);
    check("t1_p8", dig, 16'h0001);
    step(4);
    check("t1_p12", dig, 16'h0000);
    check("t1_p12v", 16'(valvula), 16'd0);
    check("t1_p12f", 16'(fim), 16'd0);
    step(1);
    check("t1_p13f", 16'(fim), 16'd1);
    check("t1_p13o", 16'(ocupado), 16'd0);
    step(1);
    check("t1_p14f", 16'(fim), 16'd0);
    check("t1_p14d", dig, 16'h0000);

    // 01:00 borrow chain, then abort with start held
    start(16'h0100);
    check("t2_load", dig, 16'h0100);
    step(4);
    check("t2_tick1", dig, 16'h0059);
    step(4);
    check("t2_tick2", dig, 16'h0058);
    set_preset(16'h0009);
    parar   = 1'b1;
    iniciar = 1'b1;
    step(1);
    check("t6_dig", dig, 16'h0058);
    check("t6_valv", 16'(valvula), 16'd0);
    check("t6_ocup", 16'(ocupado), 16'd0);
    step(1);
    check("t6_noload", dig, 16'h0058);
    check("t6_valv2", 16'(valvula), 16'd0);
    parar   = 1'b0;
    iniciar = 1'b0;
    step(1);
    check("t6_nofim", 16'(fim), 16'd0);

    // 00:05 pause after the second tick
    start(16'h0005);
    step(8);
    check("t3_tick2", dig, 16'h0003);
    pausar = 1'b1;
    step(1);
    check("t3_pvalv", 16'(valvula), 16'd0);
    check("t3_pocup", 16'(ocupado), 16'd1);
    step(9);
    check("t3_frozen", dig, 16'h0003);
    check("t3_pvalv2", 16'(valvula), 16'd0);
    pausar = 1'b0;
    step(1);
    check("t3_resume", 16'(valvula), 16'd1);
    step(3);
    check("t3_r3", dig, 16'h0003);
    step(1);
    check("t3_r4", dig, 16'h0002);
    stop();

    // invalid 00:70 then valid 00:07
    start(16'h0070);
    check("t4_erro", 16'(erro), 16'd1);
    check("t4_valv", 16'(valvula), 16'd0);
    check("t4_ocup", 16'(ocupado), 16'd0);
    check("t4_dig", dig, 16'h0002);
    step(1);
    check("t4_erro2", 16'(erro), 16'd0);
    start(16'h0007);
    check("t4_load", dig, 16'h0007);
    check("t4_valv2", 16'(valvula), 16'd1);
    check("t4_noerr", 16'(erro), 16'd0);
    stop();

    // 00:00 start goes straight to completion
    start(16'h0000);
    check("t5_dig", dig, 16'h0000);
    check("t5_valv", 16'(valvula), 16'd0);
    step(1);
    check("t5_fim", 16'(fim), 16'd1);
    check("t5_valv2", 16'(valvula), 16'd0);
    step(1);
    check("t5_fim2", 16'(fim), 16'd0);

    // async reset mid-count
    start(16'h0100);
    step(5);
    check("t7_pre", dig, 16'h0059);
    rst_n = 1'b0;
    #1;
    check("t7_dig", dig, 16'h0000);
    check("t7_valv", 16'(valvula), 16'd0);
    check("t7_ocup", 16'(ocupado), 16'd0);
    step(1);
    rst_n = 1'b1;
    step(1);
    check("t7_idle", 16'(valvula), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
